// File: rtl/relu_stream_if.sv
// Scheduler-facing handshake and BRAM/relu control bundle for the ReLU stream sequencer.
// The master drives start/abort/config; the slave (the sequencer) drives the rest.
interface relu_stream_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 11
) ();
   logic                  start;
   logic                  abort;
   logic [LEN_WIDTH-1:0]  cfg_len;
   logic [ADDR_WIDTH-1:0] cfg_src_base;
   logic [ADDR_WIDTH-1:0] cfg_dst_base;
   logic                  cfg_bypass;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  relu_bypass;
   logic                  busy;
   logic                  ready;
   logic                  done;

   modport master (
      output start, abort, cfg_len, cfg_src_base, cfg_dst_base, cfg_bypass,
      input  rd_en, rd_addr, wr_en, wr_addr, relu_bypass, busy, ready, done
   );

   modport slave (
      input  start, abort, cfg_len, cfg_src_base, cfg_dst_base, cfg_bypass,
      output rd_en, rd_addr, wr_en, wr_addr, relu_bypass, busy, ready, done
   );
endinterface

// File: rtl/relu_stream_ctrl.sv
// Sequencer streaming a run of words from the accumulator BRAM through relu into the
// output BRAM; write enables are the read enables delayed by the fixed pipeline depth.
module relu_stream_ctrl #(
   parameter int ADDR_WIDTH   = 10,
   parameter int LEN_WIDTH    = 11,
   parameter int RD_LATENCY   = 1,
   parameter int RELU_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   relu_stream_if.slave bus
);
   localparam int PIPE = RD_LATENCY + RELU_LATENCY;
   // Only the oldest slot occupied: the next cycle carries the final write.
   localparam logic [PIPE-1:0] PEND_LAST = {1'b1, {(PIPE-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} state_t;

   state_t                r_state, w_state_nx;
   logic                  r_rd_en, w_rd_en_nx;
   logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nx;
   logic [LEN_WIDTH-1:0]  r_rd_left, w_rd_left_nx;
   logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nx;
   logic [PIPE-1:0]       r_vld_p, w_vld_nx;
   logic                  r_bypass, w_bypass_nx;
   logic                  r_busy, w_busy_nx;
   logic                  r_ready, w_ready_nx;
   logic                  r_done, w_done_nx;
   logic [PIPE-1:0]       w_pend;
   logic                  w_wr_en;

   assign w_pend  = {r_vld_p[PIPE-2:0], r_rd_en};
   assign w_wr_en = r_vld_p[PIPE-1];

   always_comb begin
      w_state_nx   = r_state;
      w_rd_en_nx   = r_rd_en;
      w_rd_addr_nx = r_rd_addr;
      w_rd_left_nx = r_rd_left;
      w_wr_addr_nx = w_wr_en ? r_wr_addr + ADDR_WIDTH'(1) : r_wr_addr;
      w_vld_nx     = w_pend;
      w_bypass_nx  = r_bypass;
      w_busy_nx    = r_busy;
      w_ready_nx   = r_ready;
      w_done_nx    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               w_bypass_nx  = bus.cfg_bypass;
               w_wr_addr_nx = bus.cfg_dst_base;
               w_rd_addr_nx = bus.cfg_src_base;
               w_busy_nx    = 1'b1;
               w_ready_nx   = 1'b0;
               if (bus.cfg_len != '0) begin
                  w_state_nx   = ST_RUN;
                  w_rd_en_nx   = 1'b1;
                  w_rd_left_nx = bus.cfg_len - LEN_WIDTH'(1);
               end else begin
                  w_state_nx = ST_FIN;
               end
            end
         end
         ST_RUN: begin
            if (r_rd_left == '0) begin
               w_rd_en_nx = 1'b0;
               w_state_nx = ST_DRAIN;
            end else begin
               w_rd_addr_nx = r_rd_addr + ADDR_WIDTH'(1);
               w_rd_left_nx = r_rd_left - LEN_WIDTH'(1);
            end
         end
         ST_DRAIN: begin
            if (w_pend == PEND_LAST) w_state_nx = ST_FIN;
         end
         ST_FIN: begin
            w_done_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_ready_nx = 1'b1;
            w_state_nx = ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase

      // Cancel wins over everything, including the done pulse from FIN.
      if (bus.abort && r_state != ST_IDLE) begin
         w_state_nx = ST_IDLE;
         w_rd_en_nx = 1'b0;
         w_vld_nx   = '0;
         w_busy_nx  = 1'b0;
         w_ready_nx = 1'b1;
         w_done_nx  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_rd_left <= '0;
         r_wr_addr <= '0;
         r_vld_p   <= '0;
         r_bypass  <= 1'b0;
         r_busy    <= 1'b0;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_rd_en   <= w_rd_en_nx;
         r_rd_addr <= w_rd_addr_nx;
         r_rd_left <= w_rd_left_nx;
         r_wr_addr <= w_wr_addr_nx;
         r_vld_p   <= w_vld_nx;
         r_bypass  <= w_bypass_nx;
         r_busy    <= w_busy_nx;
         r_ready   <= w_ready_nx;
         r_done    <= w_done_nx;
      end
   end

   assign bus.rd_en       = r_rd_en;
   assign bus.rd_addr     = r_rd_addr;
   assign bus.wr_en       = w_wr_en;
   assign bus.wr_addr     = r_wr_addr;
   assign bus.relu_bypass = r_bypass;
   assign bus.busy        = r_busy;
   assign bus.ready       = r_ready;
   assign bus.done        = r_done;
endmodule
